// File: rtl/roulette_pkg.sv
// Shared constants, state encoding and helpers for the roulette round sequencer.
package roulette_pkg;

    localparam int         BET_W      = 8;
    localparam logic [5:0] OP_SPIN    = 6'b111110;
    localparam logic [5:0] OP_NONE    = 6'b111111;
    localparam logic [7:0] SERVO_REST = 8'd90;
    localparam logic [7:0] SERVO_SPIN = 8'd200;

    typedef enum logic [1:0] {
        ST_BETTING     = 2'd0,
        ST_SPIN        = 2'd1,
        ST_WAIT_RESULT = 2'd2,
        ST_SHOW        = 2'd3
    } state_e;

    // A zero-length dwell would never fire the done flag, so clamp it to one clock.
    function automatic logic [31:0] min_one(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/round_timer.sv
// Loadable 32-bit down-counter; done marks the last clock of the loaded dwell.
module round_timer (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        done,
    output logic        running
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= 32'd0;
        else       cnt_q <= cnt_d;
    end

    assign done    = (cnt_q == 32'd1);
    assign running = (cnt_q != 32'd0);

endmodule

// File: rtl/roulette_round_ctrl.sv
// Roulette game-round sequencer: bet buffering, spin, result wait and result display.
module roulette_round_ctrl
    import roulette_pkg::*;
#(
    parameter int NUM_SLOTS      = 12,
    parameter int SPIN_CYCLES    = 50_000_000,
    parameter int SHOW_CYCLES    = 100_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int DEDUP_CYCLES   = 5_000_000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       key_valid,
    input  logic [5:0]                 bet_opcode,
    input  logic [2:0]                 chip_color,
    input  logic                       result_valid,
    input  logic [5:0]                 result_number,
    output logic [BET_W*NUM_SLOTS-1:0] bets_flat,
    output logic [3:0]                 bet_count,
    output logic                       spin_check,
    output logic [7:0]                 servo_pos,
    output logic [5:0]                 shown_number,
    output logic                       result_timeout,
    output logic                       round_done,
    output logic [1:0]                 state
);

    state_e                     state_q, state_d;
    logic [BET_W*NUM_SLOTS-1:0] bets_q, bets_d;
    logic [3:0]                 bet_count_q, bet_count_d;
    logic [BET_W-1:0]           last_byte_q, last_byte_d;
    logic [5:0]                 shown_number_q, shown_number_d;
    logic                       result_timeout_q, result_timeout_d;
    logic                       round_done_q, round_done_d;

    logic        tmr_load, tmr_done, tmr_running;
    logic [31:0] tmr_val;
    logic        dedup_load, dedup_done, dedup_running;
    logic        unused_ok;

    logic [BET_W-1:0] bet_byte;
    logic             bet_ok, spin_ok;

    assign bet_byte = {chip_color[1:0], bet_opcode};

    // A repeat of the last accepted byte is keyboard bounce only while the window is open.
    assign bet_ok  = (state_q == ST_BETTING) && key_valid && (bet_opcode < OP_SPIN)
                  && (chip_color != 3'b000) && (bet_count_q < 4'(NUM_SLOTS))
                  && !(dedup_running && (bet_byte == last_byte_q));
    assign spin_ok = (state_q == ST_BETTING) && key_valid && (bet_opcode == OP_SPIN)
                  && (bet_count_q != 4'd0);

    always_comb begin
        state_d          = state_q;
        bets_d           = bets_q;
        bet_count_d      = bet_count_q;
        last_byte_d      = last_byte_q;
        shown_number_d   = shown_number_q;
        result_timeout_d = result_timeout_q;
        round_done_d     = 1'b0;
        tmr_load         = 1'b0;
        tmr_val          = 32'd0;
        dedup_load       = 1'b0;

        case (state_q)
            ST_BETTING: begin
                if (bet_ok) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (bet_count_q == 4'(i)) bets_d[i*BET_W +: BET_W] = bet_byte;
                    end
                    bet_count_d = bet_count_q + 4'd1;
                    last_byte_d = bet_byte;
                    dedup_load  = 1'b1;
                end
                if (spin_ok) begin
                    state_d  = ST_SPIN;
                    tmr_load = 1'b1;
                    tmr_val  = min_one(32'(SPIN_CYCLES));
                end
            end
            ST_SPIN: begin
                if (tmr_done) begin
                    state_d  = ST_WAIT_RESULT;
                    tmr_load = 1'b1;
                    tmr_val  = min_one(32'(TIMEOUT_CYCLES));
                end
            end
            ST_WAIT_RESULT: begin
                // A result arriving on the timeout clock still counts as a real result.
                if (result_valid) begin
                    state_d          = ST_SHOW;
                    shown_number_d   = result_number;
                    result_timeout_d = 1'b0;
                    tmr_load         = 1'b1;
                    tmr_val          = min_one(32'(SHOW_CYCLES));
                end else if (tmr_done) begin
                    state_d          = ST_SHOW;
                    result_timeout_d = 1'b1;
                    tmr_load         = 1'b1;
                    tmr_val          = min_one(32'(SHOW_CYCLES));
                end
            end
            ST_SHOW: begin
                if (tmr_done) begin
                    state_d          = ST_BETTING;
                    bets_d           = '0;
                    bet_count_d      = 4'd0;
                    result_timeout_d = 1'b0;
                    round_done_d     = 1'b1;
                end
            end
            default: state_d = ST_BETTING;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_BETTING;
            bets_q           <= '0;
            bet_count_q      <= 4'd0;
            last_byte_q      <= '0;
            shown_number_q   <= 6'd0;
            result_timeout_q <= 1'b0;
            round_done_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            bets_q           <= bets_d;
            bet_count_q      <= bet_count_d;
            last_byte_q      <= last_byte_d;
            shown_number_q   <= shown_number_d;
            result_timeout_q <= result_timeout_d;
            round_done_q     <= round_done_d;
        end
    end

    round_timer u_phase_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done),
        .running  (tmr_running)
    );

    round_timer u_dedup_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (dedup_load),
        .load_val (min_one(32'(DEDUP_CYCLES))),
        .done     (dedup_done),
        .running  (dedup_running)
    );

    assign unused_ok = &{1'b0, tmr_running, dedup_done};

    assign bets_flat      = bets_q;
    assign bet_count      = bet_count_q;
    assign spin_check     = (state_q == ST_SPIN) || (state_q == ST_WAIT_RESULT);
    assign servo_pos      = (state_q == ST_SPIN) ? SERVO_SPIN : SERVO_REST;
    assign shown_number   = shown_number_q;
    assign result_timeout = result_timeout_q;
    assign round_done     = round_done_q;
    assign state          = state_q;

endmodule

// File: tb/tb_roulette_round_ctrl.sv
// Directed bench for roulette_round_ctrl with short dwell parameters.
module tb_roulette_round_ctrl;

    localparam int NS = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          key_valid = 1'b0;
    logic [5:0]    bet_opcode = 6'b111111;
    logic [2:0]    chip_color = 3'b000;
    logic          result_valid = 1'b0;
    logic [5:0]    result_number = 6'd0;
    logic [8*NS-1:0] bets_flat;
    logic [3:0]    bet_count;
    logic          spin_check;
    logic [7:0]    servo_pos;
    logic [5:0]    shown_number;
    logic          result_timeout;
    logic          round_done;
    logic [1:0]    state;

    int checks = 0;
    int failures = 0;
    logic [8*NS-1:0] exp_bets;

    roulette_round_ctrl #(
        .NUM_SLOTS(NS), .SPIN_CYCLES(8), .SHOW_CYCLES(4),
        .TIMEOUT_CYCLES(32), .DEDUP_CYCLES(4)
    ) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid),
        .bet_opcode(bet_opcode), .chip_color(chip_color),
        .result_valid(result_valid), .result_number(result_number),
        .bets_flat(bets_flat), .bet_count(bet_count), .spin_check(spin_check),
        .servo_pos(servo_pos), .shown_number(shown_number),
        .result_timeout(result_timeout), .round_done(round_done), .state(state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic key(input logic [5:0] op, input logic [2:0] col);
        key_valid  = 1'b1;
        bet_opcode = op;
        chip_color = col;
        tick(1);
        key_valid  = 1'b0;
        bet_opcode = 6'b111111;
        chip_color = 3'b000;
    endtask

    task automatic result(input logic [5:0] num);
        result_valid  = 1'b1;
        result_number = num;
        tick(1);
        result_valid  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_state", state, 2'd0);
        check("rst_bets", bets_flat, '0);
        check("rst_count", bet_count, 4'd0);
        check("rst_servo", servo_pos, 8'd90);
        check("rst_spin_check", spin_check, 1'b0);
        check("rst_shown", shown_number, 6'd0);
        check("rst_timeout", result_timeout, 1'b0);
        check("rst_round_done", round_done, 1'b0);

        // Scenario 1: first bet
        key(6'd5, 3'b010);
        check("s1_slot0", bets_flat[7:0], 8'h85);
        check("s1_count", bet_count, 4'd1);

        // Scenario 2: dedup window and no-chip bet
        tick(1);
        key(6'd5, 3'b010);
        check("s2_dup_ignored", bet_count, 4'd1);
        tick(4);
        key(6'd5, 3'b010);
        check("s2_dup_late_count", bet_count, 4'd2);
        check("s2_slot1", bets_flat[15:8], 8'h85);
        key(6'd7, 3'b000);
        check("s2_nochip", bet_count, 4'd2);
        key(6'd9, 3'b001);
        key(6'b111111, 3'b001);
        check("s2_noop_ignored", bet_count, 4'd3);

        // Scenario 3: buffer saturation
        do_reset();
        exp_bets = '0;
        for (int i = 0; i < 14; i++) begin
            key(6'(i + 1), 3'b001);
            if (i < NS) exp_bets[i*8 +: 8] = 8'h40 + 8'(i + 1);
            if (i == 11) begin
                check("s3_count12", bet_count, 4'd12);
                check("s3_slot11", bets_flat[95:88], 8'h4c);
            end
        end
        check("s3_count_sat", bet_count, 4'd12);
        check("s3_bets_unchanged", bets_flat, exp_bets);

        // Scenario 4: full round with a result
        do_reset();
        key(6'b111110, 3'b000);
        check("s4_spin_empty", state, 2'd0);
        key(6'd3, 3'b011);
        check("s4_slot0", bets_flat[7:0], 8'hc3);
        key(6'b111110, 3'b000);
        check("s4_spin_state", state, 2'd1);
        check("s4_spin_servo", servo_pos, 8'd200);
        check("s4_spin_check", spin_check, 1'b1);
        tick(7);
        check("s4_spin_last", state, 2'd1);
        tick(1);
        check("s4_wait_state", state, 2'd2);
        check("s4_wait_servo", servo_pos, 8'd90);
        check("s4_wait_spin_check", spin_check, 1'b1);
        result(6'd17);
        check("s4_show_state", state, 2'd3);
        check("s4_shown", shown_number, 6'd17);
        check("s4_show_timeout", result_timeout, 1'b0);
        check("s4_show_spin_check", spin_check, 1'b0);
        tick(3);
        check("s4_show_last", state, 2'd3);
        check("s4_no_done_early", round_done, 1'b0);
        tick(1);
        check("s4_back_betting", state, 2'd0);
        check("s4_round_done", round_done, 1'b1);
        check("s4_count_clr", bet_count, 4'd0);
        check("s4_bets_clr", bets_flat, '0);
        tick(1);
        check("s4_done_pulse", round_done, 1'b0);

        // Scenario 5: timeout, ignored inputs in SPIN and SHOW
        key(6'd9, 3'b001);
        check("s5_bet", bet_count, 4'd1);
        key(6'b111110, 3'b000);
        key(6'd10, 3'b001);
        result(6'd33);
        check("s5_spin_ignore_bet", bet_count, 4'd1);
        check("s5_spin_ignore_result", shown_number, 6'd17);
        tick(6);
        check("s5_wait_state", state, 2'd2);
        tick(31);
        check("s5_wait_last", state, 2'd2);
        tick(1);
        check("s5_show_state", state, 2'd3);
        check("s5_timeout", result_timeout, 1'b1);
        check("s5_shown_kept", shown_number, 6'd17);
        key(6'd11, 3'b001);
        result(6'd5);
        tick(1);
        check("s5_show_ignore_result", shown_number, 6'd17);
        check("s5_show_ignore_bet", bet_count, 4'd1);
        check("s5_show_still", state, 2'd3);
        tick(1);
        check("s5_back_betting", state, 2'd0);
        check("s5_round_done", round_done, 1'b1);
        check("s5_timeout_clr", result_timeout, 1'b0);

        // Scenario 6: reset mid-spin
        key(6'd2, 3'b001);
        key(6'b111110, 3'b000);
        check("s6_spin", state, 2'd1);
        reset = 1'b1;
        tick(1);
        check("s6_rst_state", state, 2'd0);
        check("s6_rst_servo", servo_pos, 8'd90);
        check("s6_rst_spin_check", spin_check, 1'b0);
        check("s6_rst_count", bet_count, 4'd0);
        check("s6_rst_bets", bets_flat, '0);
        reset = 1'b0;
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/roulette_round_ctrl.md
# roulette_round_ctrl

Game-round sequencer for the roulette table. Sits between the PS/2 bet decoder, the Arduino chip-colour inputs, the processor/regfile and the wheel servo. It buffers up to 12 bets, starts a spin on command, drives the servo, and waits for the processor's winning number. It then holds the result, clears the bet buffer and re-opens betting.

## Interface
- NUM_SLOTS, 12, bet buffer depth (max 15)
- SPIN_CYCLES, 50_000_000, clocks the servo is held at SERVO_SPIN
- SHOW_CYCLES, 100_000_000, clocks the result is held before re-opening betting
- TIMEOUT_CYCLES, 500_000_000, max clocks waiting for result_valid
- DEDUP_CYCLES, 5_000_000, window in which a repeat of the last accepted bet byte is ignored
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- key_valid  in  1  one-cycle pulse: bet_opcode is new
- bet_opcode  in  6  decoded key; 6'b111110 = SPIN, 6'b111111 = no-op
- chip_color  in  3  Arduino chip colour; 3'b000 = no chip
- result_valid  in  1  one-cycle pulse from processor side: result_number valid
- result_number  in  6  winning pocket 0..36
- bets_flat  out  8*NUM_SLOTS  slot i at [8i+7:8i] = {chip_color[1:0], bet_opcode}
- bet_count  out  4  occupied slots
- spin_check  out  1  high during SPIN and WAIT_RESULT
- servo_pos  out  8  servo target position
- shown_number  out  6  last latched winning number
- result_timeout  out  1  high in SHOW when the result timed out
- round_done  out  1  one-cycle pulse on SHOW -> BETTING
- state  out  2  current state encoding

## Operation
- States: BETTING=0, SPIN=1, WAIT_RESULT=2, SHOW=3. Reset enters BETTING.
- Reset values:
  - bets_flat=0, bet_count=0, spin_check=0, servo_pos=SERVO_REST (8'd90)
  - shown_number=0, result_timeout=0, round_done=0, state=BETTING
  - dedup history cleared
- Bet accept, in BETTING only. All of the following must hold:
  - key_valid
  - bet_opcode < 6'b111110
  - chip_color != 0
  - bet_count < NUM_SLOTS
  - not a duplicate: {chip_color[1:0],bet_opcode} equals the last accepted byte while the dedup timer is running
- On accept: write slot[bet_count], increment bet_count, restart the dedup timer.
- Full buffer: further bets are ignored. No overwrite, no wrap.
- Spin accept, in BETTING only: key_valid && bet_opcode==SPIN && bet_count>=1. A spin with zero bets is ignored.
- BETTING -> SPIN on spin accept. servo_pos=SERVO_SPIN (8'd200), spin_check=1.
- SPIN -> WAIT_RESULT after exactly SPIN_CYCLES clocks in SPIN. servo_pos returns to SERVO_REST.
- WAIT_RESULT -> SHOW:
  - on result_valid: latch result_number into shown_number, result_timeout=0
  - on TIMEOUT_CYCLES elapsed: shown_number unchanged, result_timeout=1
  - if result_valid and the timeout fall in the same cycle, result_valid wins
- SHOW -> BETTING after SHOW_CYCLES. On that edge: clear bets_flat and bet_count, pulse round_done, clear result_timeout.
- key_valid outside BETTING and result_valid outside WAIT_RESULT are ignored. They are not queued.

## Timing
- Accepted bet is visible in bets_flat and bet_count on the edge after the key_valid cycle (1-cycle latency).
- Spin accept sets state=SPIN and spin_check=1 on the next edge.
- Each state's dwell is exactly its parameter in clocks, counted from the entry edge.
- Timers are 32-bit. A parameter of 0 is treated as 1.
- round_done is high for exactly one cycle, coincident with state returning to BETTING.
- Reset mid-round restores all reset values on the next edge, regardless of state.

## Structure
- Package roulette_pkg holds:
  - OP_SPIN, OP_NONE
  - SERVO_REST, SERVO_SPIN
  - the state encoding
  - BET_W=8
- One sub-module, round_timer:
  - loadable 32-bit down-counter with a done flag
  - one instance shared across SPIN/WAIT_RESULT/SHOW, reloaded on each state entry
  - a second instance serves as the dedup timer

## Test plan
All scenarios use SPIN_CYCLES=8, SHOW_CYCLES=4, TIMEOUT_CYCLES=32, DEDUP_CYCLES=4.
1. Reset, then key_valid with opcode 6'd5 and colour 3'b010 -> next cycle bets_flat[7:0]=8'h85, bet_count=1.
2. Same byte repeated 2 cycles later -> ignored. Repeated after 6 cycles -> slot1=8'h85, bet_count=2. Colour 000 bet -> ignored.
3. Issue 14 distinct valid bets -> bet_count saturates at 12, slot11 holds the 12th bet, slots unchanged afterwards.
4. SPIN with bet_count=0 -> stays BETTING. SPIN with 1 bet:
   - SPIN for 8 cycles with servo_pos=200, spin_check=1
   - then WAIT_RESULT with servo_pos=90
   - result_valid with 6'd17 -> SHOW, shown_number=17
   - after 4 cycles: round_done pulse, bet_count=0, bets_flat=0
5. WAIT_RESULT with no result_valid -> SHOW after 32 cycles with result_timeout=1. A result_valid or a bet key sent during SPIN or SHOW -> ignored.
6. Assert reset during SPIN -> next cycle state=BETTING, servo_pos=90, spin_check=0, bet_count=0.
